add_serial_ctrl: RTL and testbench

Byte-serial multi-byte adder controller. It computes an N-byte sum by time-multiplexing a single `add_8` slice (8-bit `a`, `b`, `cin` → `s`, `co`) over N clock cycles, least-significant byte first, with the carry held in a register between bytes. The block sits between a requesting unit and the shared `add_8` datapath and provides a start/busy/done handshake. Results and flags are held stable until the next accepted start.

---
 rtl/add_serial_ctrl_if.sv | 25 ++
 rtl/add_serial_ctrl.sv | 133 +++++++++++++
 tb/tb_add_serial_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_serial_ctrl_if.sv
// Request/result bundle between a requesting unit and add_serial_ctrl.
// Handshake: start is sampled only while busy=0; done pulses for one cycle with sum/co/ovf valid, and those hold until the next done.
interface add_serial_ctrl_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   sum;
  logic                  co;
  logic                  ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, co, ovf
  );
endinterface

// File: rtl/add_serial_ctrl.sv
// Byte-serial N-byte adder: one shared 8-bit adder slice walks the operands LSB first,
// carrying between bytes in a register; start/busy/done handshake with held results.
module add_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module add_serial_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  add_serial_ctrl_if.slave  bus,
  output logic [1:0]        o_state
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_sum;
  logic            r_co;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_s;
  logic            w_co;
  logic [W-1:0]    w_sum_final;
  logic            w_last;
  logic            w_ovf;

  // Byte select for the slice inputs, and the accumulator with the current byte merged in.
  always_comb begin
    w_a_byte    = '0;
    w_b_byte    = '0;
    w_sum_final = r_acc;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_byte             = r_opa[8*i +: 8];
        w_b_byte             = r_opb[8*i +: 8];
        w_sum_final[8*i +: 8] = w_s;
      end
    end
  end

  assign w_last = (r_cnt == CW'(NBYTES - 1));
  assign w_ovf  = (r_opa[W-1] == r_opb[W-1]) && (w_sum_final[W-1] != r_opa[W-1]);

  add_8 u_add_8 (
    .a   (w_a_byte),
    .b   (w_b_byte),
    .cin (r_carry),
    .s   (w_s),
    .co  (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_opa   <= bus.a;
            r_opb   <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_sum_final;
          r_carry <= w_co;
          if (w_last) begin
            r_sum   <= w_sum_final;
            r_co    <= w_co;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.co   = r_co;
  assign bus.ovf  = r_ovf;
  assign o_state  = r_state;
endmodule

// File: tb/tb_add_serial_ctrl.sv
// Directed bench for add_serial_ctrl at NBYTES=4 and NBYTES=1 with a queue scoreboard.
module tb_add_serial_ctrl;
  logic clk;
  logic rst_n;
  logic [1:0] st4;
  logic [1:0] st1;

  add_serial_ctrl_if #(.NBYTES(4)) bus4 ();
  add_serial_ctrl_if #(.NBYTES(1)) bus1 ();

  add_serial_ctrl #(.NBYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .o_state(st4));
  add_serial_ctrl #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .o_state(st1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  logic [33:0] exp_q4[$];
  logic [9:0]  exp_q1[$];
  logic [31:0] prev_sum4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitors: pop one expected entry per done pulse
  task automatic monitor4();
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (bus4.done === 1'b1) begin
        if (exp_q4.size() == 0) begin
          check("dut4_spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q4.pop_front();
          check("dut4_sum", 64'(bus4.sum), 64'(e[31:0]));
          check("dut4_co",  64'(bus4.co),  64'(e[32]));
          check("dut4_ovf", 64'(bus4.ovf), 64'(e[33]));
        end
      end
    end
  endtask

  task automatic monitor1();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin
        if (exp_q1.size() == 0) begin
          check("dut1_spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q1.pop_front();
          check("dut1_sum", 64'(bus1.sum), 64'(e[7:0]));
          check("dut1_co",  64'(bus1.co),  64'(e[8]));
          check("dut1_ovf", 64'(bus1.ovf), 64'(e[9]));
        end
      end
    end
  endtask

  // driver: one operation on the 4-byte instance, checking latency, busy width and result hold
  task automatic run_op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [31:0] esum, input logic eco, input logic eovf);
    int busy_cnt;
    int lat;
    bit got;
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.start = 1'b1;
    exp_q4.push_back({eovf, eco, esum});
    @(posedge clk); #1;
    bus4.start = 1'b0;
    busy_cnt = (bus4.busy === 1'b1) ? 1 : 0;
    lat = 0; got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus4.busy === 1'b1) busy_cnt++;
      if (bus4.busy === 1'b1 && bus4.done !== 1'b1) check("dut4_sum_hold", 64'(bus4.sum), 64'(prev_sum4));
      if (bus4.done === 1'b1 && !got) begin got = 1; lat = k; end
      if (got && bus4.busy !== 1'b1) break;
    end
    check("dut4_done_seen", 64'(got), 64'd1);
    check("dut4_latency", 64'(lat), 64'd4);
    check("dut4_busy_cycles", 64'(busy_cnt), 64'd5);
    prev_sum4 = esum;
  endtask

  task automatic run_op1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] esum, input logic eco, input logic eovf);
    int busy_cnt;
    int lat;
    bit got;
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
    exp_q1.push_back({eovf, eco, esum});
    @(posedge clk); #1;
    bus1.start = 1'b0;
    busy_cnt = (bus1.busy === 1'b1) ? 1 : 0;
    lat = 0; got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus1.busy === 1'b1) busy_cnt++;
      if (bus1.done === 1'b1 && !got) begin got = 1; lat = k; end
      if (got && bus1.busy !== 1'b1) break;
    end
    check("dut1_done_seen", 64'(got), 64'd1);
    check("dut1_latency", 64'(lat), 64'd1);
    check("dut1_busy_cycles", 64'(busy_cnt), 64'd2);
  endtask

  initial begin
    int n_done;
    int last_cyc;
    n_checks = 0;
    n_errors = 0;
    prev_sum4 = '0;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    fork
      monitor4();
      monitor1();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus4.busy), 64'd0);
    check("rst_done", 64'(bus4.done), 64'd0);
    check("rst_sum",  64'(bus4.sum),  64'd0);
    check("rst_co_ovf", 64'({bus4.co, bus4.ovf}), 64'd0);
    check("rst_state", 64'(st4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op4(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op4(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op4(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op4(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op4(32'hC000_0000, 32'hC000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0);

    // start and operand changes during RUN and DONE must be ignored
    @(negedge clk);
    bus4.a = 32'h1234_5678; bus4.b = 32'h1111_1111; bus4.cin = 1'b0; bus4.start = 1'b1;
    exp_q4.push_back({1'b0, 1'b0, 32'h2345_6789});
    @(posedge clk);
    n_done = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus4.a = 32'hFFFF_FFFF - 32'(k); bus4.b = 32'hFFFF_FFFF; bus4.cin = 1'b1; bus4.start = 1'b1;
      @(posedge clk); #1;
      if (bus4.done === 1'b1) n_done++;
    end
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) n_done++;
    end
    check("ignore_done_count", 64'(n_done), 64'd1);
    check("ignore_idle_after", 64'(bus4.busy), 64'd0);
    prev_sum4 = 32'h2345_6789;

    // start held high: back-to-back operations
    @(negedge clk);
    bus4.a = 32'h0000_0003; bus4.b = 32'h0000_0004; bus4.cin = 1'b1; bus4.start = 1'b1;
    repeat (3) exp_q4.push_back({1'b0, 1'b0, 32'h0000_0008});
    n_done = 0; last_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) begin
        if (n_done > 0) check("b2b_spacing", 64'(c - last_cyc), 64'd6);
        last_cyc = c;
        n_done++;
        if (n_done == 3) begin
          bus4.start = 1'b0;
          break;
        end
      end
    end
    check("b2b_done_count", 64'(n_done), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle_after", 64'(bus4.busy), 64'd0);
    prev_sum4 = 32'h0000_0008;

    // reset asserted on the second RUN cycle
    @(negedge clk);
    bus4.a = 32'hAAAA_AAAA; bus4.b = 32'h5555_5555; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_state", 64'(st4), 64'd0);
    check("midrun_rst_busy", 64'(bus4.busy), 64'd0);
    check("midrun_rst_sum", 64'(bus4.sum), 64'd0);
    check("midrun_rst_flags", 64'({bus4.done, bus4.co, bus4.ovf}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrun_rst_hold", 64'({st4, bus4.busy, bus4.done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum4 = '0;
    run_op4(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);

    // single-byte instance
    run_op1(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
    run_op1(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op1(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("dut4_queue_empty", 64'(exp_q4.size()), 64'd0);
    check("dut1_queue_empty", 64'(exp_q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
